// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg: shared widths, coin values, timing limits and state encoding
package change_dispenser_pkg;
    localparam int W = 10;
    localparam logic [W-1:0] TL_VALUE = W'(100);
    localparam logic [W-1:0] HALF_VALUE = W'(50);
    localparam int ACK_TIMEOUT = 255;
    localparam int GAP_CYCLES = 4;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, SELECT, WAIT_TL, WAIT_HALF, GAP, DONE, FAULT} state_t;
endpackage

// File: rtl/change_dispenser_handshake_timer.sv
// handshake_timer: up-counter cleared on clr, flags when the count equals limit
module handshake_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [CW-1:0] limit,
    output logic          tc
);
    logic [CW-1:0] count_q, count_d;
    always_comb count_d = clr ? '0 : count_q + CW'(1);
    always_ff @(posedge clk)
        if (rst) count_q <= '0;
        else count_q <= count_d;
    assign tc = (count_q == limit);
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: greedy two-tube coin payout with per-coin request/ack handshake
module change_dispenser
    import change_dispenser_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [W-1:0] change_in,
    input  logic         tl_empty,
    input  logic         half_empty,
    output logic         eject_tl,
    output logic         eject_half,
    input  logic         hopper_ack,
    input  logic         clear,
    output logic         busy,
    output logic         done,
    output logic         fault,
    output logic [W-1:0] remaining,
    output logic [3:0]   coins_paid
);
    state_t state_q, state_d;
    logic [W-1:0] remaining_q, remaining_d;
    logic [3:0] coins_q, coins_d;
    logic tc;
    always_comb begin
        state_d = state_q;
        remaining_d = remaining_q;
        coins_d = coins_q;
        case (state_q)
            IDLE:
                if (load_valid) begin
                    remaining_d = change_in;
                    coins_d = '0;
                    state_d = SELECT;
                end
            SELECT:
                state_d = (remaining_q == '0) ? DONE :
                          (remaining_q >= TL_VALUE && !tl_empty) ? WAIT_TL :
                          (remaining_q >= HALF_VALUE && !half_empty) ? WAIT_HALF : FAULT;
            WAIT_TL, WAIT_HALF:
                if (hopper_ack) begin
                    remaining_d = remaining_q - ((state_q == WAIT_TL) ? TL_VALUE : HALF_VALUE);
                    coins_d = coins_q + 4'(coins_q != 4'hF);
                    state_d = GAP;
                end else if (tc) begin
                    state_d = FAULT;
                end
            GAP: state_d = tc ? SELECT : GAP;
            DONE: state_d = IDLE;
            FAULT: state_d = clear ? IDLE : FAULT;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (rst) begin
            state_q <= IDLE;
            remaining_q <= '0;
            coins_q <= '0;
        end else begin
            state_q <= state_d;
            remaining_q <= remaining_d;
            coins_q <= coins_d;
        end
    // Timer restarts on every state change, so it counts cycles spent in the current WAIT or GAP.
    handshake_timer #(.CW(TW)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_d != state_q),
        .limit((state_q == GAP) ? TW'(GAP_CYCLES - 1) : TW'(ACK_TIMEOUT - 1)),
        .tc   (tc)
    );
    assign load_ready = (state_q == IDLE);
    assign busy = (state_q != IDLE);
    assign eject_tl = (state_q == WAIT_TL);
    assign eject_half = (state_q == WAIT_HALF);
    assign done = (state_q == DONE);
    assign fault = (state_q == FAULT);
    assign remaining = remaining_q;
    assign coins_paid = coins_q;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: table-driven payouts plus directed latency, fault, timeout and reset sequences
module tb_change_dispenser;
    logic clk = 0, rst = 1, load_valid = 0, tl_empty = 0, half_empty = 0, hopper_ack = 0, clear = 0;
    logic [9:0] change_in = '0;
    logic load_ready, eject_tl, eject_half, busy, done, fault;
    logic [9:0] remaining;
    logic [3:0] coins_paid;
    int checks = 0, fails = 0;
    bit ack_en = 1;
    int ack_delay = 3, wait_cnt = 0;
    int tl_rises, half_rises, done_cnt, gap, min_gap;
    bit prev_tl, prev_half, seen;

    typedef struct {
        int amt; bit tle; bit hle;
        int tl_n; int half_n; int coins; int rem; bit flt; int dn;
    } vec_t;
    vec_t vecs[9];

    change_dispenser dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .change_in(change_in), .tl_empty(tl_empty), .half_empty(half_empty),
        .eject_tl(eject_tl), .eject_half(eject_half), .hopper_ack(hopper_ack),
        .clear(clear), .busy(busy), .done(done), .fault(fault),
        .remaining(remaining), .coins_paid(coins_paid)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk); #1;
        if (ack_en && (eject_tl || eject_half)) begin
            wait_cnt++;
            hopper_ack = (wait_cnt == ack_delay);
        end else begin
            wait_cnt = 0;
            hopper_ack = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (eject_tl && !prev_tl) tl_rises++;
        if (eject_half && !prev_half) half_rises++;
        if ((eject_tl && !prev_tl) || (eject_half && !prev_half)) begin
            if (seen && gap < min_gap) min_gap = gap;
            seen = 1;
            gap = 0;
        end else if (!eject_tl && !eject_half) gap++;
        if (done) done_cnt++;
        prev_tl = eject_tl;
        prev_half = eject_half;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        tl_rises = 0; half_rises = 0; done_cnt = 0; gap = 0; seen = 0;
    endtask

    task automatic load(int amt);
        load_valid = 1;
        change_in = 10'(amt);
        tick();
        load_valid = 0;
    endtask

    task automatic wait_end(string name);
        int n = 0;
        while (!(done || fault) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) check({name, "_end_timeout"}, 0, 1);
    endtask

    initial begin
        int len;
        vecs[0] = '{150, 0, 0, 1, 1, 2, 0, 0, 1};
        vecs[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        vecs[2] = '{200, 1, 0, 0, 4, 4, 0, 0, 1};
        vecs[3] = '{70, 0, 0, 0, 1, 1, 20, 1, 0};
        vecs[4] = '{250, 0, 0, 2, 1, 3, 0, 0, 1};
        vecs[5] = '{100, 1, 1, 0, 0, 0, 100, 1, 0};
        vecs[6] = '{130, 0, 1, 1, 0, 1, 30, 1, 0};
        vecs[7] = '{1023, 0, 0, 10, 0, 10, 23, 1, 0};
        vecs[8] = '{1000, 1, 0, 0, 20, 15, 0, 0, 1};
        clr_mon();
        prev_tl = 0; prev_half = 0;
        tick(); tick();
        rst = 0;
        check("rst_load_ready", load_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_eject", {eject_tl, eject_half}, 0);
        check("rst_done_fault", {done, fault}, 0);
        check("rst_remaining", remaining, 0);
        check("rst_coins", coins_paid, 0);

        min_gap = 1000;
        foreach (vecs[i]) begin
            tl_empty = vecs[i].tle;
            half_empty = vecs[i].hle;
            clr_mon();
            load(vecs[i].amt);
            wait_end($sformatf("v%0d", i));
            tick(); tick();
            check($sformatf("v%0d_tl_ejects", i), tl_rises, vecs[i].tl_n);
            check($sformatf("v%0d_half_ejects", i), half_rises, vecs[i].half_n);
            check($sformatf("v%0d_coins", i), coins_paid, vecs[i].coins);
            check($sformatf("v%0d_remaining", i), remaining, vecs[i].rem);
            check($sformatf("v%0d_fault", i), fault, vecs[i].flt);
            check($sformatf("v%0d_done_pulses", i), done_cnt, vecs[i].dn);
            if (fault) begin
                clear = 1;
                tick();
                clear = 0;
                check($sformatf("v%0d_clear_ready", i), load_ready, 1);
            end
        end
        check("min_gap_ok", int'(min_gap >= 4), 1);
        tl_empty = 0; half_empty = 0;

        load(0);
        check("zero_edge1_done", done, 0);
        check("zero_edge1_busy", busy, 1);
        tick();
        check("zero_edge2_done", done, 1);
        check("zero_edge2_eject", {eject_tl, eject_half}, 0);
        tick();
        check("zero_after_done", done, 0);
        check("zero_ready", load_ready, 1);

        load(150);
        check("lat_edge1_eject", eject_tl, 0);
        tick();
        check("lat_edge2_eject_tl", eject_tl, 1);
        check("lat_edge2_eject_half", eject_half, 0);
        wait_end("lat");
        check("lat_remaining", remaining, 0);

        tick();
        load(70);
        wait_end("flt");
        check("flt_fault", fault, 1);
        check("flt_busy", busy, 1);
        check("flt_ready", load_ready, 0);
        load(500);
        tick();
        check("flt_ignore_load", remaining, 20);
        check("flt_sticky", fault, 1);
        clear = 1;
        tick();
        clear = 0;
        check("flt_clear_fault", fault, 0);
        check("flt_clear_ready", load_ready, 1);

        ack_en = 0;
        load(100);
        tick();
        len = 0;
        while (eject_tl && len < 400) begin
            tick();
            len++;
        end
        check("to_len_ok", int'(len >= 255 && len <= 256), 1);
        check("to_fault", fault, 1);
        check("to_eject_dropped", eject_tl, 0);
        check("to_remaining", remaining, 100);
        clear = 1;
        tick();
        clear = 0;

        load(150);
        tick(); tick();
        check("rst_seq_eject_tl", eject_tl, 1);
        load(300);
        check("busy_load_ignored", remaining, 150);
        rst = 1;
        tick();
        check("midrst_eject", {eject_tl, eject_half}, 0);
        check("midrst_remaining", remaining, 0);
        check("midrst_coins", coins_paid, 0);
        check("midrst_flags", {done, fault, busy}, 0);
        check("midrst_ready", load_ready, 1);
        rst = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream of the vending controller; takes the change amount it computes (kuruş, 10-bit) and pays it out coin by coin.
- Drives a two-tube coin hopper (1 TL and 50 krs) using a per-coin request/acknowledge handshake.
- Uses greedy selection, with the largest coin first.
- Reports progress, completion, and a sticky fault when the amount cannot be paid or the hopper stops responding.

Parameters:
- W, 10, width of amount and remaining
- TL_VALUE, 100, value of 1 TL coin in kuruş
- HALF_VALUE, 50, value of 50 krs coin in kuruş
- ACK_TIMEOUT, 255, maximum cycles in a WAIT state before fault
- GAP_CYCLES, 4, idle cycles between consecutive coin requests (hopper settle)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- load_valid  in  1  change_in is valid this cycle
- load_ready  out  1  high only in IDLE; a load is accepted when load_valid & load_ready at a clk edge
- change_in  in  W  amount to pay out, in kuruş
- tl_empty  in  1  1 TL tube empty
- half_empty  in  1  50 krs tube empty
- eject_tl  out  1  request one 1 TL coin; level, held until acknowledged
- eject_half  out  1  request one 50 krs coin; level, held until acknowledged
- hopper_ack  in  1  hopper has released the requested coin
- clear  in  1  leaves FAULT, synchronous
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse when remaining reaches 0
- fault  out  1  sticky fault flag
- remaining  out  W  amount still to pay
- coins_paid  out  4  coins released for the current load; saturates at 15

Behaviour:
- Reset values (next edge after rst=1, from any state): state=IDLE, eject_tl=0, eject_half=0, done=0, fault=0, remaining=0, coins_paid=0, timers=0. load_ready=1 after reset.
- rst overrides everything, including the middle of a handshake. A pending eject drops immediately.
- State IDLE
  - On accept: remaining<=change_in, coins_paid<=0, go to SELECT.
  - load_valid while not IDLE is ignored; nothing is latched.
- State SELECT (exactly one cycle), evaluated in priority order:
  - remaining==0 → DONE.
  - remaining>=TL_VALUE and !tl_empty → WAIT_TL, eject_tl<=1.
  - remaining>=HALF_VALUE and !half_empty → WAIT_HALF, eject_half<=1.
  - Otherwise → FAULT. This covers a residual below HALF_VALUE (e.g. 20) and both needed tubes being empty.
- Latency: eject is high on the 2nd edge after the accept edge. A zero amount gives done on the 2nd edge with no eject.
- State WAIT_TL / WAIT_HALF
  - hopper_ack is sampled every cycle, including the first cycle eject is high.
  - On ack: eject<=0, remaining-=coin value, coins_paid+=1 (saturating), timer<=0, go to GAP.
  - If ACK_TIMEOUT cycles pass without ack: eject<=0, go to FAULT; remaining is unchanged.
- State GAP: counts GAP_CYCLES cycles, then goes to SELECT. hopper_ack is ignored outside the WAIT states.
- State DONE: done=1 for exactly one cycle, then IDLE. remaining stays 0 and coins_paid holds until the next accept.
- State FAULT
  - fault=1, busy=1, load_ready=0.
  - remaining and coins_paid hold their values for diagnosis.
  - clear=1 → IDLE with fault<=0. rst also exits.
- Tube-empty inputs are sampled only in SELECT. A change while in WAIT does not cancel the outstanding request.
- Arithmetic: subtraction is unsigned W-bit and is guarded by the SELECT comparisons, so it never underflows.

Decomposition:
- Shared package holds:
  - state encoding: IDLE, SELECT, WAIT_TL, WAIT_HALF, GAP, DONE, FAULT
  - coin value constants: TL_VALUE=100, HALF_VALUE=50, matching the controller's coin codes
  - amount width W=10, shared with the controller's change/balance outputs
- One sub-module, handshake_timer: loadable up-counter with terminal-count flag. It is reused for the ACK_TIMEOUT watchdog and the GAP_CYCLES delay.

Test Plan:
- change_in=150, both tubes full, ack 3 cycles after each eject → exactly one eject_tl then one eject_half; remaining 150→50→0; coins_paid=2; done pulses once; fault=0.
- change_in=0 → done on the 2nd edge after accept; no eject ever asserted; back in IDLE with load_ready=1.
- change_in=200, tl_empty=1 → four eject_half handshakes, each separated by ≥GAP_CYCLES idle cycles; coins_paid=4; done.
- change_in=70 → one eject_half; remaining=20; then FAULT with fault=1, remaining=20, load_ready=0. A load_valid pulse is ignored. clear=1 returns to IDLE.
- change_in=100, hopper_ack never asserted → eject_tl is dropped and fault=1 after ACK_TIMEOUT cycles; remaining stays 100.
- rst=1 while in WAIT_TL with change_in=150 → next edge: all outputs at reset values and eject_tl=0. A load_valid during busy (before the rst) leaves remaining unchanged.
